regfile_wb: RTL and testbench
=============================

REGFILE_WB -- requirements
Module: regfile_wb

Purpose: GPR write-back stage of the multi-cycle MIPS datapath. Consumes the 5-bit write address from the rt/rd destination select and the write-back data, and serves rs/rt operand reads.

Interface
Parameters
REQ-001 SHALL provide parameter BYPASS, default 0; 1 = a read of the address being written this cycle returns the write data.
REQ-002 SHALL provide parameter DEPTH_LOG2, default 5, fixed at 5; any other value is unsupported.

Ports
REQ-003 SHALL provide clk, input, 1, rising-edge clock.
REQ-004 SHALL provide rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL provide RF_W, input, 1, GPR write enable.
REQ-006 SHALL provide Waddr, input, 5, GPR write address (destination select output).
REQ-007 SHALL provide Wdata, input, 32, GPR write data.
REQ-008 SHALL provide Raddr1, input, 5, rs read address.
REQ-009 SHALL provide Raddr2, input, 5, rt read address.
REQ-010 SHALL provide Rdata1, output, 32, rs read data.
REQ-011 SHALL provide Rdata2, output, 32, rt read data.
REQ-012 SHALL provide HI_W, input, 1, HI write enable.
REQ-013 SHALL provide LO_W, input, 1, LO write enable.
REQ-014 SHALL provide HI_in, input, 32, HI write data.
REQ-015 SHALL provide LO_in, input, 32, LO write data.
REQ-016 SHALL provide HI_out, output, 32, HI value.
REQ-017 SHALL provide LO_out, output, 32, LO value.
REQ-018 SHALL provide wr_cnt, output, 16, count of committed GPR writes (debug).

Function
REQ-019 SHALL hold 32 x 32-bit GPRs; writes commit on the rising clk edge when RF_W=1 and Waddr!=0.
REQ-020 SHALL ignore writes to register 0; Rdata1/Rdata2 for address 0 SHALL always be 32'h0, regardless of BYPASS.
REQ-021 SHALL make reads combinational (zero latency): with BYPASS=0, Rdata reflects the stored value and a write becomes visible the cycle after its edge.
REQ-022 SHALL, with BYPASS=1, return Wdata on a read port whose address equals Waddr while RF_W=1 and Waddr!=0, in the same cycle.
REQ-023 SHALL update HI on an edge with HI_W=1 and LO on an edge with LO_W=1, each independently; simultaneous HI_W and LO_W SHALL update both on the same edge.
REQ-024 SHALL present HI_out/LO_out directly from registers, one-cycle latency from write.
REQ-025 SHALL increment wr_cnt by 1 on each edge that commits a GPR write (RF_W=1, Waddr!=0); writes to register 0 SHALL NOT count.
REQ-026 SHALL wrap wr_cnt from 16'hFFFF to 16'h0000.
REQ-027 SHALL make RF_W, HI_W and LO_W fully independent; any combination asserted in one cycle SHALL commit all enabled writes.
REQ-028 SHALL let the last edge win for repeated writes to the same address on consecutive cycles; there is no merging.
REQ-029 SHALL treat X on Waddr while RF_W=0 as don't-care: no state change.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously clear all GPRs, HI, LO and wr_cnt to 0, without waiting for a clk edge.
REQ-031 SHALL, on reset asserted mid-cycle with RF_W=1, discard the pending write; no write commits on any edge while rst_n=0.
REQ-032 SHALL accept writes from the first rising edge after rst_n deasserts.

Verification
REQ-033 Bench SHALL cover: reset then read all 32 addresses -> all Rdata=0, HI_out=LO_out=0, wr_cnt=0.
REQ-034 Bench SHALL cover: write Waddr=5, Wdata=32'hDEADBEEF, then read Raddr1=5 the next cycle -> Rdata1=32'hDEADBEEF, wr_cnt=1.
REQ-035 Bench SHALL cover: write Waddr=0, Wdata=32'hFFFFFFFF -> Rdata1(0)=0, wr_cnt unchanged.
REQ-036 Bench SHALL cover: BYPASS=1, same-cycle write and read of r7 with Wdata=32'h12345678 -> Rdata2=32'h12345678 before the edge; BYPASS=0 -> old value 0.
REQ-037 Bench SHALL cover: HI_W=LO_W=1 with HI_in=32'h1, LO_in=32'h2 plus RF_W to r31 in the same cycle -> HI_out=1, LO_out=2, r31 written, wr_cnt+1.
REQ-038 Bench SHALL cover: preset wr_cnt to 16'hFFFF via 65535 writes, one more write -> wr_cnt=0; then pulse rst_n low between edges -> all state 0 immediately.

Source files
------------

// File: rtl/regfile_wb.sv
// regfile_wb: GPR write-back stage of the multi-cycle MIPS datapath.
// Holds 32x32 GPRs (r0 hardwired to zero), HI/LO, and a debug write counter.
//
// Ports:
//   clk, rst_n           rising-edge clock, async active-low reset
//   RF_W, Waddr, Wdata   GPR write port (commits on edge, ignored for r0)
//   Raddr1/Rdata1        rs combinational read port
//   Raddr2/Rdata2        rt combinational read port
//   HI_W, HI_in, HI_out  HI register write/read
//   LO_W, LO_in, LO_out  LO register write/read
//   wr_cnt               count of committed GPR writes, wraps at 16 bits
//
// Parameters:
//   BYPASS      1 = a read of the address being written returns Wdata
//   DEPTH_LOG2  register-file address width; only 5 is supported
module regfile_wb #(
    parameter int BYPASS     = 0,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RF_W,
    input  logic [4:0]  Waddr,
    input  logic [31:0] Wdata,
    input  logic [4:0]  Raddr1,
    input  logic [4:0]  Raddr2,
    output logic [31:0] Rdata1,
    output logic [31:0] Rdata2,
    input  logic        HI_W,
    input  logic        LO_W,
    input  logic [31:0] HI_in,
    input  logic [31:0] LO_in,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out,
    output logic [15:0] wr_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0] regs [DEPTH];
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [15:0] cnt_q;
    logic        we;

    // RF_W gates the address compare, so an unknown Waddr while
    // RF_W=0 can never produce a write.
    assign we = RF_W && (Waddr != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[Waddr] <= Wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
        end else if (HI_W) begin
            hi_q <= HI_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q <= '0;
        end else if (LO_W) begin
            lo_q <= LO_in;
        end
    end

    // Natural 16-bit overflow provides the FFFF -> 0000 wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (we) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    // r0 is forced to zero ahead of the bypass check, so a stray
    // write to r0 is never forwarded either.
    always_comb begin
        Rdata1 = regs[Raddr1];
        if (Raddr1 == 5'd0) begin
            Rdata1 = '0;
        end else if ((BYPASS != 0) && we && (Raddr1 == Waddr)) begin
            Rdata1 = Wdata;
        end
    end

    always_comb begin
        Rdata2 = regs[Raddr2];
        if (Raddr2 == 5'd0) begin
            Rdata2 = '0;
        end else if ((BYPASS != 0) && we && (Raddr2 == Waddr)) begin
            Rdata2 = Wdata;
        end
    end

    assign HI_out = hi_q;
    assign LO_out = lo_q;
    assign wr_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: directed self-checking bench for regfile_wb.
// Drives one no-bypass and one bypass instance from shared inputs.
module tb_regfile_wb;

    logic        clk;
    logic        rst_n;
    logic        RF_W;
    logic [4:0]  Waddr;
    logic [31:0] Wdata;
    logic [4:0]  Raddr1;
    logic [4:0]  Raddr2;
    logic        HI_W;
    logic        LO_W;
    logic [31:0] HI_in;
    logic [31:0] LO_in;

    logic [31:0] rd1_a, rd2_a, hi_a, lo_a;
    logic [15:0] cnt_a;
    logic [31:0] rd1_b, rd2_b, hi_b, lo_b;
    logic [15:0] cnt_b;

    int errors = 0;
    int checks = 0;

    regfile_wb #(.BYPASS(0), .DEPTH_LOG2(5)) dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .RF_W   (RF_W),
        .Waddr  (Waddr),
        .Wdata  (Wdata),
        .Raddr1 (Raddr1),
        .Raddr2 (Raddr2),
        .Rdata1 (rd1_a),
        .Rdata2 (rd2_a),
        .HI_W   (HI_W),
        .LO_W   (LO_W),
        .HI_in  (HI_in),
        .LO_in  (LO_in),
        .HI_out (hi_a),
        .LO_out (lo_a),
        .wr_cnt (cnt_a)
    );

    regfile_wb #(.BYPASS(1), .DEPTH_LOG2(5)) dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .RF_W   (RF_W),
        .Waddr  (Waddr),
        .Wdata  (Wdata),
        .Raddr1 (Raddr1),
        .Raddr2 (Raddr2),
        .Rdata1 (rd1_b),
        .Rdata2 (rd2_b),
        .HI_W   (HI_W),
        .LO_W   (LO_W),
        .HI_in  (HI_in),
        .LO_in  (LO_in),
        .HI_out (hi_b),
        .LO_out (lo_b),
        .wr_cnt (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RF_W = 1'b0;
        HI_W = 1'b0;
        LO_W = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        RF_W   = 1'b0;
        Waddr  = '0;
        Wdata  = '0;
        Raddr1 = '0;
        Raddr2 = '0;
        HI_W   = 1'b0;
        LO_W   = 1'b0;
        HI_in  = '0;
        LO_in  = '0;
        step();
        step();
        rst_n = 1'b1;

        // Reset state: every address reads zero on both ports.
        for (int i = 0; i < 32; i++) begin
            Raddr1 = 5'(i);
            Raddr2 = 5'(31 - i);
            #1;
            chk($sformatf("rst_rd1_r%0d", i), rd1_a, 32'h0);
            chk($sformatf("rst_rd2_r%0d", 31 - i), rd2_a, 32'h0);
        end
        chk("rst_hi", hi_a, 32'h0);
        chk("rst_lo", lo_a, 32'h0);
        chk("rst_cnt", {16'h0, cnt_a}, 32'h0);

        // Plain write to r5, visible the next cycle.
        RF_W  = 1'b1;
        Waddr = 5'd5;
        Wdata = 32'hDEADBEEF;
        Raddr1 = 5'd5;
        #1;
        chk("nobyp_r5_before", rd1_a, 32'h0);
        step();
        idle();
        #1;
        chk("r5_after", rd1_a, 32'hDEADBEEF);
        chk("cnt_after_r5", {16'h0, cnt_a}, 32'd1);

        // Write to r0 is dropped and never forwarded.
        RF_W   = 1'b1;
        Waddr  = 5'd0;
        Wdata  = 32'hFFFFFFFF;
        Raddr1 = 5'd0;
        #1;
        chk("byp_r0_same_cycle", rd1_b, 32'h0);
        step();
        idle();
        #1;
        chk("r0_after_a", rd1_a, 32'h0);
        chk("r0_after_b", rd1_b, 32'h0);
        chk("cnt_r0_a", {16'h0, cnt_a}, 32'd1);
        chk("cnt_r0_b", {16'h0, cnt_b}, 32'd1);

        // Same-cycle write and read of r7.
        RF_W   = 1'b1;
        Waddr  = 5'd7;
        Wdata  = 32'h12345678;
        Raddr1 = 5'd5;
        Raddr2 = 5'd7;
        #1;
        chk("byp_r7", rd2_b, 32'h12345678);
        chk("nobyp_r7", rd2_a, 32'h0);
        chk("byp_other_port", rd1_b, 32'hDEADBEEF);
        step();
        idle();
        #1;
        chk("r7_after_a", rd2_a, 32'h12345678);
        chk("cnt_r7", {16'h0, cnt_a}, 32'd2);

        // HI, LO and a GPR write all in one cycle.
        RF_W   = 1'b1;
        Waddr  = 5'd31;
        Wdata  = 32'hA5A5A5A5;
        HI_W   = 1'b1;
        LO_W   = 1'b1;
        HI_in  = 32'h1;
        LO_in  = 32'h2;
        Raddr1 = 5'd31;
        #1;
        chk("hi_before_edge", hi_a, 32'h0);
        step();
        idle();
        #1;
        chk("hi_both", hi_a, 32'h1);
        chk("lo_both", lo_a, 32'h2);
        chk("r31", rd1_a, 32'hA5A5A5A5);
        chk("cnt_r31", {16'h0, cnt_a}, 32'd3);

        // HI alone leaves LO and GPRs untouched.
        HI_W  = 1'b1;
        HI_in = 32'h33;
        step();
        idle();
        LO_W  = 1'b1;
        LO_in = 32'h44;
        step();
        idle();
        #1;
        chk("hi_only", hi_a, 32'h33);
        chk("lo_only", lo_a, 32'h44);
        chk("cnt_hilo", {16'h0, cnt_a}, 32'd3);

        // Consecutive writes to r9: the later one wins.
        RF_W  = 1'b1;
        Waddr = 5'd9;
        Wdata = 32'h111;
        step();
        Wdata = 32'h222;
        step();
        idle();
        Raddr1 = 5'd9;
        #1;
        chk("r9_last_wins", rd1_a, 32'h222);
        chk("cnt_r9", {16'h0, cnt_a}, 32'd5);

        // Unknown Waddr with RF_W low changes nothing.
        Waddr = 'x;
        Wdata = 32'hFFFFFFFF;
        step();
        Raddr1 = 5'd5;
        #1;
        chk("x_waddr_r5", rd1_a, 32'hDEADBEEF);
        chk("x_waddr_cnt", {16'h0, cnt_a}, 32'd5);

        // Drive wr_cnt from 5 up to FFFF, then wrap.
        for (int k = 0; k < 65530; k++) begin
            RF_W  = 1'b1;
            Waddr = 5'd1;
            Wdata = 32'(k);
            step();
        end
        idle();
        Raddr1 = 5'd1;
        #1;
        chk("cnt_ffff", {16'h0, cnt_a}, 32'h0000FFFF);
        chk("r1_last", rd1_a, 32'd65529);
        RF_W  = 1'b1;
        Waddr = 5'd2;
        Wdata = 32'hCAFE0002;
        step();
        idle();
        #1;
        chk("cnt_wrap_a", {16'h0, cnt_a}, 32'h0);
        chk("cnt_wrap_b", {16'h0, cnt_b}, 32'h0);

        // Mid-cycle reset with a pending write.
        RF_W   = 1'b1;
        Waddr  = 5'd3;
        Wdata  = 32'h0BADF00D;
        Raddr1 = 5'd31;
        Raddr2 = 5'd3;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_r31", rd1_a, 32'h0);
        chk("arst_hi", hi_a, 32'h0);
        chk("arst_lo", lo_a, 32'h0);
        chk("arst_cnt", {16'h0, cnt_a}, 32'h0);
        step();
        chk("rst_edge_r3", rd2_a, 32'h0);
        chk("rst_edge_cnt", {16'h0, cnt_a}, 32'h0);
        #2;
        rst_n = 1'b1;
        step();
        chk("post_rst_r3", rd2_a, 32'h0BADF00D);
        chk("post_rst_cnt", {16'h0, cnt_a}, 32'd1);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
